vn_serial_update: RTL and testbench

//  Degree-parametrised, time-multiplexed variable-node processor for the LDPC decoder.

---
 rtl/vn_serial_update_if.sv | 28 ++
 rtl/vn_serial_update.sv | 110 +++++++++++
 tb/tb_vn_serial_update.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vn_serial_update_if.sv
// Handshake bundle for the serial variable-node processor.
// The upstream/downstream side uses master; the node processor uses slave.
interface vn_serial_update_if #(
  parameter int W  = 16,
  parameter int IW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_llr;
  logic [W-1:0]  in_msg;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_msg;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [W-1:0]  belief;
  logic          hard_bit;

  modport master (
    output in_valid, in_llr, in_msg, out_ready,
    input  in_ready, out_valid, out_msg, out_idx, out_last, belief, hard_bit
  );

  modport slave (
    input  in_valid, in_llr, in_msg, out_ready,
    output in_ready, out_valid, out_msg, out_idx, out_last, belief, hard_bit
  );
endinterface

// File: rtl/vn_serial_update.sv
// Time-multiplexed LDPC variable node: serial C2V in, serial saturated extrinsic V2C out.
//   state   | meaning
//   ST_ACC  | accepting LLR + DV messages, accumulating exactly
//   ST_EMIT | presenting DV extrinsic messages, belief and hard bit
module vn_serial_update #(
  parameter int INT  = 8,
  parameter int FRAC = 8,
  parameter int DV   = 3,
  localparam int W   = INT + FRAC,
  localparam int IW  = $clog2(DV),
  localparam int AW  = W + $clog2(DV + 1) + 1
) (
  input logic              clk,
  input logic              rst_n,
  vn_serial_update_if.slave vn
);

  typedef enum logic {ST_ACC, ST_EMIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   count_q;
  logic [IW-1:0]   idx_q;
  logic [AW-1:0]   acc_q;
  logic [W-1:0]    msg_buf [DV];

  logic            accept_in;
  logic            accept_out;
  logic            idx_at_end;
  logic            count_at_end;

  function automatic logic [AW-1:0] sext(input logic [W-1:0] v);
    return {{(AW-W){v[W-1]}}, v};
  endfunction

  // In range exactly when every bit from W-1 upward equals the sign.
  function automatic logic [W-1:0] sat_w(input logic [AW-1:0] v);
    logic [AW-W:0] top;
    top = v[AW-1:W-1];
    if ((&top) || !(|top))
      return v[W-1:0];
    else if (v[AW-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  assign count_at_end = (count_q == IW'(DV - 1));
  assign idx_at_end   = (idx_q == IW'(DV - 1));
  assign accept_in    = vn.in_valid && (state_q == ST_ACC);
  assign accept_out   = vn.out_ready && (state_q == ST_EMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (accept_in && count_at_end) state_d = ST_EMIT;
      ST_EMIT: if (accept_out && idx_at_end)  state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    vn.in_ready  = 1'b0;
    vn.out_valid = 1'b0;
    vn.out_msg   = '0;
    vn.out_idx   = '0;
    vn.out_last  = 1'b0;
    vn.belief    = '0;
    vn.hard_bit  = 1'b0;
    case (state_q)
      ST_ACC: vn.in_ready = 1'b1;
      ST_EMIT: begin
        vn.out_valid = 1'b1;
        vn.out_msg   = sat_w(acc_q - sext(msg_buf[idx_q]));
        vn.out_idx   = idx_q;
        vn.out_last  = idx_at_end;
        vn.belief    = sat_w(acc_q);
        vn.hard_bit  = vn.belief[W-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      if (accept_in) begin
        count_q <= count_at_end ? '0 : count_q + IW'(1);
        if (count_q == '0) acc_q <= sext(vn.in_llr) + sext(vn.in_msg);
        else               acc_q <= acc_q + sext(vn.in_msg);
      end
      if (accept_out)
        idx_q <= idx_at_end ? '0 : idx_q + IW'(1);
    end
  end

  // Message storage needs no reset: it is always rewritten before it is read.
  always_ff @(posedge clk) begin
    if (rst_n && accept_in)
      msg_buf[count_q] <= vn.in_msg;
  end

endmodule

// File: tb/tb_vn_serial_update.sv
// Directed bench for vn_serial_update: DV=3 instance plus a DV=6 instance.
module tb_vn_serial_update;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vn_serial_update_if #(.W(16), .IW(2)) vif ();
  vn_serial_update_if #(.W(16), .IW(3)) vif6 ();

  vn_serial_update #(.INT(8), .FRAC(8), .DV(3)) dut (.clk(clk), .rst_n(rst_n), .vn(vif));
  vn_serial_update #(.INT(8), .FRAC(8), .DV(6)) dut6 (.clk(clk), .rst_n(rst_n), .vn(vif6));

  // Drives one node on consecutive negedges; in ACC every beat is taken.
  task automatic send3(input logic [15:0] llr, input logic [15:0] m0,
                       input logic [15:0] m1, input logic [15:0] m2);
    logic [47:0] m;
    m = {m2, m1, m0};
    for (int k = 0; k < 3; k++) begin
      vif.in_valid = 1'b1;
      vif.in_llr   = (k == 0) ? llr : 16'hDEAD;
      vif.in_msg   = m[k*16 +: 16];
      @(negedge clk);
    end
    vif.in_valid = 1'b0;
  endtask

  // Gathers three output beats with out_ready high; flags a timeout.
  task automatic collect3(output logic [47:0] msgs, output logic [5:0] idxs,
                          output logic [2:0] lasts, output logic [15:0] bel,
                          output logic hb, output bit to);
    int n;
    msgs = '0; idxs = '0; lasts = '0; bel = '0; hb = 1'b0; to = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!vif.out_valid && n < 50) begin @(negedge clk); n++; end
      if (!vif.out_valid) begin to = 1'b1; return; end
      msgs[k*16 +: 16] = vif.out_msg;
      idxs[k*2 +: 2]   = vif.out_idx;
      lasts[k]         = vif.out_last;
      if (k == 0) begin bel = vif.belief; hb = vif.hard_bit; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (vif.in_ready !== 1'b1 || vif.out_valid !== 1'b0 || vif.out_idx !== 2'd0 ||
        vif.out_last !== 1'b0 || vif.out_msg !== 16'h0 || vif.belief !== 16'h0 ||
        vif.hard_bit !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b idx=%0d last=%b msg=%h bel=%h hb=%b, want 1 0 0 0 0000 0000 0",
               vif.in_ready, vif.out_valid, vif.out_idx, vif.out_last, vif.out_msg, vif.belief, vif.hard_bit);
    end
  endtask

  task automatic test_node(input string name, input logic [15:0] llr, input logic [15:0] m0,
                           input logic [15:0] m1, input logic [15:0] m2,
                           input logic [15:0] e_bel, input logic e_hb, input logic [47:0] e_msgs);
    logic [47:0] msgs; logic [5:0] idxs; logic [2:0] lasts; logic [15:0] bel; logic hb; bit to;
    vif.out_ready = 1'b1;
    send3(llr, m0, m1, m2);
    collect3(msgs, idxs, lasts, bel, hb, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: no complete output within budget", name); end
    checks++;
    if (bel !== e_bel || hb !== e_hb) begin
      errors++;
      $display("FAIL %s_belief: got %h/%b, want %h/%b", name, bel, hb, e_bel, e_hb);
    end
    checks++;
    if (msgs !== e_msgs) begin
      errors++;
      $display("FAIL %s_msgs: got %h, want %h (idx2..idx0)", name, msgs, e_msgs);
    end
    checks++;
    if (idxs !== 6'b10_01_00 || lasts !== 3'b100) begin
      errors++;
      $display("FAIL %s_idx_last: got idx=%b last=%b, want 100100 100", name, idxs, lasts);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] m_hold, b_hold;
    vif.out_ready = 1'b0;
    send3(16'h0100, 16'h0080, 16'h0040, 16'hFF00);
    n = 0;
    while (!vif.out_valid && n < 20) begin @(negedge clk); n++; end
    vif.out_ready = 1'b1;
    @(negedge clk);
    vif.out_ready = 1'b0;
    m_hold = 16'h0080; b_hold = 16'h00C0;
    for (int c = 0; c < 5; c++) begin
      // Hold an input beat to confirm it is ignored during EMIT.
      vif.in_valid = 1'b1; vif.in_llr = 16'h7777; vif.in_msg = 16'h7777;
      @(negedge clk);
      checks++;
      if (vif.out_valid !== 1'b1 || vif.in_ready !== 1'b0 || vif.out_idx !== 2'd1 ||
          vif.out_msg !== m_hold || vif.belief !== b_hold || vif.hard_bit !== 1'b0 ||
          vif.out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b idx=%0d msg=%h bel=%h last=%b, want 1 0 1 %h %h 0",
                 c, vif.out_valid, vif.in_ready, vif.out_idx, vif.out_msg, vif.belief, vif.out_last, m_hold, b_hold);
      end
    end
    vif.in_valid = 1'b0;
    vif.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (vif.out_idx !== 2'd2 || vif.out_msg !== 16'h01C0 || vif.out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: idx=%0d msg=%h last=%b, want 2 01c0 1", vif.out_idx, vif.out_msg, vif.out_last);
    end
    @(negedge clk);
    checks++;
    if (vif.out_valid !== 1'b0 || vif.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_return: out_valid=%b in_ready=%b, want 0 1", vif.out_valid, vif.in_ready);
    end
  endtask

  task automatic test_reset_mid_node();
    vif.in_valid = 1'b1; vif.in_llr = 16'h1234; vif.in_msg = 16'h4321;
    @(negedge clk);
    vif.in_llr = 16'h0000; vif.in_msg = 16'h2222;
    @(negedge clk);
    vif.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (vif.in_ready !== 1'b1 || vif.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b, want 1 0", vif.in_ready, vif.out_valid);
    end
    test_node("after_reset", 16'h0100, 16'h0080, 16'h0040, 16'hFF00,
              16'h00C0, 1'b0, {16'h01C0, 16'h0080, 16'h0040});
  endtask

  task automatic test_back_to_back();
    logic [15:0] s_llr [4] = '{16'h0100, 16'h0000, 16'hFF00, 16'h7F00};
    logic [15:0] s_msg [12] = '{16'h0080, 16'h0040, 16'hFF00,
                                16'h0001, 16'h0002, 16'h0003,
                                16'hFF80, 16'h0010, 16'h0020,
                                16'h7F00, 16'h7F00, 16'h7F00};
    logic [15:0] e_msg [12] = '{16'h0040, 16'h0080, 16'h01C0,
                                16'h0005, 16'h0004, 16'h0003,
                                16'hFF30, 16'hFEA0, 16'hFE90,
                                16'h7FFF, 16'h7FFF, 16'h7FFF};
    logic [15:0] e_bel [4] = '{16'h00C0, 16'h0006, 16'hFEB0, 16'h7FFF};
    logic [15:0] r_msg [12];
    logic [15:0] r_bel [12];
    logic [1:0]  r_idx [12];
    logic        r_last [12];
    int          r_cyc [12];
    int          got;
    got = 0;
    vif.out_ready = 1'b1;
    fork
      begin
        int b = 0; int n = 0; logic take;
        vif.in_valid = 1'b1;
        while (b < 12 && n < 200) begin
          vif.in_llr = s_llr[b/3];
          vif.in_msg = s_msg[b];
          take = vif.in_ready;
          @(negedge clk); n++;
          if (take) b++;
        end
        vif.in_valid = 1'b0;
      end
      begin
        int n = 0;
        while (got < 12 && n < 300) begin
          if (vif.out_valid) begin
            r_msg[got] = vif.out_msg; r_bel[got] = vif.belief;
            r_idx[got] = vif.out_idx; r_last[got] = vif.out_last; r_cyc[got] = cyc;
            got++;
          end
          @(negedge clk); n++;
        end
      end
    join
    checks++;
    if (got != 12) begin
      errors++;
      $display("FAIL stream_count: got %0d beats, want 12", got);
    end else begin
      for (int j = 0; j < 12; j++) begin
        checks++;
        if (r_msg[j] !== e_msg[j] || r_bel[j] !== e_bel[j/3] || r_idx[j] !== 2'(j % 3) ||
            r_last[j] !== (j % 3 == 2)) begin
          errors++;
          $display("FAIL stream_beat%0d: msg=%h bel=%h idx=%0d last=%b, want %h %h %0d %b",
                   j, r_msg[j], r_bel[j], r_idx[j], r_last[j], e_msg[j], e_bel[j/3], j % 3, (j % 3 == 2));
        end
      end
      for (int nd = 1; nd < 4; nd++) begin
        checks++;
        if (r_cyc[3*nd+2] - r_cyc[3*nd-1] != 6) begin
          errors++;
          $display("FAIL stream_period%0d: %0d cycles, want 6", nd, r_cyc[3*nd+2] - r_cyc[3*nd-1]);
        end
      end
    end
  endtask

  task automatic test_dv6();
    int n;
    logic [15:0] e;
    vif6.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vif6.in_valid = 1'b1;
      vif6.in_llr   = 16'h0000;
      vif6.in_msg   = 16'(k + 1);
      @(negedge clk);
    end
    vif6.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!vif6.out_valid && n < 50) begin @(negedge clk); n++; end
      e = 16'(20 - k);
      checks++;
      if (vif6.out_valid !== 1'b1 || vif6.out_msg !== e || vif6.belief !== 16'd21 ||
          vif6.out_idx !== 3'(k) || vif6.out_last !== (k == 5)) begin
        errors++;
        $display("FAIL dv6_beat%0d: valid=%b msg=%0d bel=%0d idx=%0d last=%b, want 1 %0d 21 %0d %b",
                 k, vif6.out_valid, vif6.out_msg, vif6.belief, vif6.out_idx, vif6.out_last, e, k, (k == 5));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    vif.in_valid = 1'b0; vif.in_llr = '0; vif.in_msg = '0; vif.out_ready = 1'b1;
    vif6.in_valid = 1'b0; vif6.in_llr = '0; vif6.in_msg = '0; vif6.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_node("nominal", 16'h0100, 16'h0080, 16'h0040, 16'hFF00,
              16'h00C0, 1'b0, {16'h01C0, 16'h0080, 16'h0040});
    test_node("sat_pos", 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
              16'h7FFF, 1'b0, {16'h7FFF, 16'h7FFF, 16'h7FFF});
    test_node("sat_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000,
              16'h8000, 1'b1, {16'h8000, 16'h8000, 16'h8000});
    test_backpressure();
    test_reset_mid_node();
    test_back_to_back();
    test_dv6();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
